cmp_flags_unit: RTL
===================

# cmp_flags_unit

Registered, parametrised successor to the combinational flag generator. It captures Z/N/C/V from a WIDTH-bit ALU result under a per-flag write mask, and holds them in a flag register. It evaluates a 4-bit condition code against the held flags and provides a DEPTH-entry save/restore stack for exception entry and return. It sits between the ALU adder/result mux and the branch/predication logic of the execute stage.

## Interface
Parameters:
- WIDTH, 32, result width; Z/N computed over WIDTH bits; legal 8..64
- DEPTH, 4, flag-stack entries; legal 1..16

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- upd_valid  in  1  ALU result valid this cycle
- upd_mask  in  4  per-flag write enable, indexed by `ALU_FLAG_Z/N/C/V`
- y  in  WIDTH  ALU result
- carry_in  in  1  unsigned carry-out from adder
- overflow_in  in  1  signed overflow from adder
- flags  out  4  registered flags, indexed by `ALU_FLAG_*`
- cond  in  4  condition-code select
- cond_true  out  1  condition evaluated on current `flags`
- push  in  1  save `flags` onto stack
- pop  in  1  restore `flags` from stack
- stk_full  out  1  stack holds DEPTH entries
- stk_empty  out  1  stack holds 0 entries
- stk_err  out  1  sticky stack-misuse indicator
- sov  out  1  sticky overflow (see Configuration)
- sov_clr  in  1  clear `sov`

## Operation
- Candidate flags: Z = (y == 0); N = y[WIDTH-1]; C = carry_in; V = overflow_in.
- Update: on a clock edge with upd_valid=1, each flag bit i with upd_mask[i]=1 loads its candidate. Unmasked bits hold. upd_valid=0 means no change.
- cond decode:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0
- Stack: LIFO of 4-bit entries. Occupancy counter runs 0..DEPTH. stk_empty = (count==0); stk_full = (count==DEPTH).
- push (pop=0, not full): writes current `flags` (pre-update value) at top; count+1.
- pop (push=0, not empty): next `flags` = top entry; count-1.
- pop with upd_valid in the same cycle: the restored entry is the base, then upd_mask bits override with candidates (update wins per bit).
- push with upd_valid in the same cycle: pushes the pre-update flags; the update applies to `flags`.
- Error cases (each sets stk_err; count and stack contents unchanged):
  - push when full: no write.
  - pop when empty: no restore from stack; upd still applies.
  - push and pop together: neither happens.
- stk_err is cleared only by rst.

## Timing
- Reset values: flags=4'b0000; count=0 (stk_empty=1, stk_full=0); stk_err=0; sov=0. Stack entry contents are don't-care.
- rst has priority over all inputs in its cycle, including mid-sequence push/pop. A rst in the middle of a push/pop sequence discards the whole stack.
- Latency:
  - flags reflect upd/pop one cycle after the capturing edge.
  - cond_true is combinational from `flags` and `cond` (zero added latency). There is no forwarding of same-cycle candidates.
- stk_full, stk_empty, stk_err and sov are registered and change on the same edge as the count or event.
- Back-to-back push/pop on consecutive cycles is allowed at full rate.
- Push in the cycle after pop sees the restored flags.

## Configuration
- `CMP_FLAGS_STICKY_OV_EN`
  - Defined: sov sets on any edge where upd_valid & upd_mask[`ALU_FLAG_V`] & overflow_in. sov_clr clears it. Set wins over a same-cycle clear. sov is not saved on the stack.
  - Undefined: sov is constant 0, sov_clr is ignored, and no register is inferred.

## Test plan
- Reset, WIDTH=32: assert rst with push=1 and upd_valid=1 -> next cycle flags=0000, stk_empty=1, stk_err=0, sov=0.
- Update with mask 1111, y=32'h0, C=1, V=0 -> Z=1, N=0, C=1, V=0.
  - cond=0 (EQ) -> 1; cond=8 (HI) -> 0.
  - Then y=32'h8000_0000 with mask Z,N only -> Z=0, N=1, C still 1.
- Signed compare, flags N=1, V=0: cond=11 (LT) -> 1; cond=10 (GE) -> 0; cond=13 (LE) -> 1; cond=15 -> 0; cond=14 -> 1.
- DEPTH=4, sequence 1:
  - Push four distinct flag values -> stk_full=1. A 5th push sets stk_err=1 with count still 4.
  - Four pops restore the values in reverse order -> stk_empty=1.
  - A 5th pop leaves flags unchanged; stk_err stays 1.
- DEPTH=4, sequence 2:
  - Push and pop in the same cycle -> stk_err=1, count unchanged.
  - Pop together with upd_valid, mask=`ALU_FLAG_C`, carry_in=0, top entry C=1, Z=1 -> flags Z=1, C=0.
- With macro defined:
  - overflow_in=1 with V masked -> sov=1.
  - Three later clean updates -> sov stays 1.
  - sov_clr together with a new overflow -> sov=1.
  - sov_clr alone -> sov=0.
  - Without macro: sov=0 throughout.

Source files
------------

// File: rtl/cmp_flags_unit.sv
// ============================================================================
//  Module      : cmp_flags_unit
//  Description : Registered Z/N/C/V flag unit. Captures flags from an ALU
//                result under a per-flag write mask, evaluates a 4-bit
//                condition code against the held flags, and keeps a
//                DEPTH-entry LIFO of flag snapshots for exception entry and
//                return.
//                Optional feature macro: CMP_FLAGS_STICKY_OV_EN (sticky
//                overflow bit `sov`, cleared by `sov_clr`).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ALU_FLAG_Z
`define ALU_FLAG_Z 0
`endif
`ifndef ALU_FLAG_N
`define ALU_FLAG_N 1
`endif
`ifndef ALU_FLAG_C
`define ALU_FLAG_C 2
`endif
`ifndef ALU_FLAG_V
`define ALU_FLAG_V 3
`endif

module cmp_flags_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    input  logic [3:0]       upd_mask,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    input  logic             overflow_in,
    output logic [3:0]       flags,
    input  logic [3:0]       cond,
    output logic             cond_true,
    input  logic             push,
    input  logic             pop,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err,
    output logic             sov,
    input  logic             sov_clr
);

    // Occupancy needs to represent 0..DEPTH; stack address needs 0..DEPTH-1.
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]      r_flags;
    logic [c_CW-1:0] r_count;
    logic [3:0]      r_stack [DEPTH];
    logic            r_err;

    logic [3:0]      w_cand;
    logic [3:0]      w_base;
    logic [3:0]      w_flags_nxt;
    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic            w_misuse;
    logic [c_AW-1:0] w_top_idx;
    logic [c_AW-1:0] w_wr_idx;
    logic            w_z;
    logic            w_n;
    logic            w_c;
    logic            w_v;

    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_empty   = (r_count == '0);

    // Simultaneous push and pop is treated as misuse: neither takes effect.
    assign w_push_ok = push & ~pop & ~w_full;
    assign w_pop_ok  = pop & ~push & ~w_empty;
    assign w_misuse  = (push & pop) | (push & w_full) | (pop & w_empty);

    assign w_top_idx = c_AW'(r_count - 1'b1);
    assign w_wr_idx  = c_AW'(r_count);

    // Candidate flags straight from the ALU result and adder status.
    always_comb begin
        w_cand              = 4'b0000;
        w_cand[`ALU_FLAG_Z] = (y == '0);
        w_cand[`ALU_FLAG_N] = y[WIDTH-1];
        w_cand[`ALU_FLAG_C] = carry_in;
        w_cand[`ALU_FLAG_V] = overflow_in;
    end

    // A restore supplies the base value; masked update bits override it.
    assign w_base      = w_pop_ok ? r_stack[w_top_idx] : r_flags;
    assign w_flags_nxt = upd_valid ? ((w_base & ~upd_mask) | (w_cand & upd_mask))
                                   : w_base;

    // Flag register, stack occupancy and sticky misuse indicator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 4'b0000;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            if (w_push_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (w_misuse) begin
                r_err <= 1'b1;
            end
        end
    end

    // Stack storage; saves the pre-update flags. Contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_stack[w_wr_idx] <= r_flags;
        end
    end

    assign w_z = r_flags[`ALU_FLAG_Z];
    assign w_n = r_flags[`ALU_FLAG_N];
    assign w_c = r_flags[`ALU_FLAG_C];
    assign w_v = r_flags[`ALU_FLAG_V];

    // Condition-code evaluation on the held flags only (no forwarding).
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:    cond_true = w_z;
            4'd1:    cond_true = ~w_z;
            4'd2:    cond_true = w_c;
            4'd3:    cond_true = ~w_c;
            4'd4:    cond_true = w_n;
            4'd5:    cond_true = ~w_n;
            4'd6:    cond_true = w_v;
            4'd7:    cond_true = ~w_v;
            4'd8:    cond_true = w_c & ~w_z;
            4'd9:    cond_true = ~w_c | w_z;
            4'd10:   cond_true = (w_n == w_v);
            4'd11:   cond_true = (w_n != w_v);
            4'd12:   cond_true = ~w_z & (w_n == w_v);
            4'd13:   cond_true = w_z | (w_n != w_v);
            4'd14:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign flags     = r_flags;
    assign stk_full  = w_full;
    assign stk_empty = w_empty;
    assign stk_err   = r_err;

`ifdef CMP_FLAGS_STICKY_OV_EN
    logic r_sov;

    // Sticky overflow: a same-cycle set beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sov <= 1'b0;
        end else if (upd_valid & upd_mask[`ALU_FLAG_V] & overflow_in) begin
            r_sov <= 1'b1;
        end else if (sov_clr) begin
            r_sov <= 1'b0;
        end
    end

    assign sov = r_sov;
`else
    // Feature disabled: constant zero, the clear input has no effect.
    assign sov = sov_clr & 1'b0;
`endif

endmodule

`default_nettype wire
